// File: rtl/muxencoder_rr_sched.sv
// muxencoder_rr_sched: round-robin share of one fixed-latency pipeline, with tags
// that steer each pipeline output back to the requester that issued it.
module muxencoder_rr_sched #(
    parameter int NREQ         = 4,
    parameter int DW           = 8,
    parameter int LAT          = 7,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_enable,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      pipe_in_data,
    output logic               pipe_in_valid,
    input  logic [DW-1:0]      pipe_out_data,
    input  logic               pipe_out_valid,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               idle,
    output logic               busy,
    output logic               err_orphan
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int BW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [BW-1:0] blank_cnt;
    logic [LAT:0]  tag_v;
    logic [PW-1:0] tag_id [LAT+1];
    logic          accept;
    logic          matched;
    logic          orphan;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win = rr_ptr;
        idx = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = PW'((int'(rr_ptr) + j) % NREQ);
            if (req_valid[idx]) win = idx;
        end
    end

    assign accept       = state == RUN && cfg_enable && inflight < CW'(MAX_INFLIGHT) && |req_valid;
    assign req_ready    = accept ? NREQ'(1) << win : '0;
    // Stage 0 travels with pipe_in, so stage LAT lines up with pipe_out.
    assign matched      = pipe_out_valid && blank_cnt == '0 && tag_v[LAT];
    assign orphan       = pipe_out_valid && blank_cnt == '0 && !tag_v[LAT];
    assign rsp_valid    = matched ? NREQ'(1) << tag_id[LAT] : '0;
    assign rsp_data     = pipe_out_data;
    assign inflight_nxt = inflight + CW'(accept) - CW'(matched);
    assign idle         = state == IDLE;
    assign busy         = inflight != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            inflight      <= '0;
            blank_cnt     <= BW'(LAT);
            pipe_in_valid <= 1'b0;
            pipe_in_data  <= '0;
            err_orphan    <= 1'b0;
            tag_v         <= '0;
            for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
        end else begin
            rr_ptr        <= accept ? PW'((int'(win) + 1) % NREQ) : rr_ptr;
            inflight      <= inflight_nxt;
            blank_cnt     <= blank_cnt - BW'(blank_cnt != '0);
            pipe_in_valid <= accept;
            pipe_in_data  <= accept ? req_data[win*DW +: DW] : '0;
            err_orphan    <= err_orphan | orphan;
            tag_v         <= {tag_v[LAT-1:0], accept};
            tag_id[0]     <= win;
            for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
            unique case (state)
                IDLE:    state <= cfg_enable ? RUN : IDLE;
                RUN:     state <= cfg_enable ? RUN : DRAIN;
                DRAIN:   state <= cfg_enable ? RUN : (inflight_nxt == '0 ? IDLE : DRAIN);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muxencoder_rr_sched.sv
// tb_muxencoder_rr_sched: directed and random stimulus against a queue-based model,
// with a second instance capped at two in-flight items.
module tb_muxencoder_rr_sched;
    localparam int LAT = 7;
    localparam int MAXI = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  rv = '0;
    logic [31:0] rd = '0;
    logic        inj = 1'b0;
    logic [3:0]  ready1, rsp1;
    logic [7:0]  pin_d1, rsp_d1;
    logic        pin_v1, idle1, busy1, err1;
    logic        en2 = 1'b0;
    logic [3:0]  ready2, rsp2;
    logic [7:0]  pin_d2, rsp_d2;
    logic        pin_v2, idle2, busy2, err2;
    bit          p1_v [LAT];
    bit [7:0]    p1_d [LAT];
    bit          p2_v [LAT];
    bit [7:0]    p2_d [LAT];

    always #5 clk = ~clk;

    muxencoder_rr_sched dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(en), .req_valid(rv), .req_data(rd),
        .req_ready(ready1), .pipe_in_data(pin_d1), .pipe_in_valid(pin_v1),
        .pipe_out_data(p1_d[LAT-1]), .pipe_out_valid(p1_v[LAT-1] | inj),
        .rsp_valid(rsp1), .rsp_data(rsp_d1), .idle(idle1), .busy(busy1), .err_orphan(err1)
    );

    muxencoder_rr_sched #(.MAX_INFLIGHT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_enable(en2), .req_valid(4'b0010), .req_data(32'h00C3_0000),
        .req_ready(ready2), .pipe_in_data(pin_d2), .pipe_in_valid(pin_v2),
        .pipe_out_data(p2_d[LAT-1]), .pipe_out_valid(p2_v[LAT-1]),
        .rsp_valid(rsp2), .rsp_data(rsp_d2), .idle(idle2), .busy(busy2), .err_orphan(err2)
    );

    // Unreset delay lines standing in for the shared pipeline.
    always @(posedge clk) begin
        p1_v[0] <= pin_v1;
        p1_d[0] <= pin_d1;
        p2_v[0] <= pin_v2;
        p2_d[0] <= pin_d2;
        for (int i = 1; i < LAT; i++) begin
            p1_v[i] <= p1_v[i-1];
            p1_d[i] <= p1_d[i-1];
            p2_v[i] <= p2_v[i-1];
            p2_d[i] <= p2_d[i-1];
        end
    end

    typedef struct { int due; int k; logic [7:0] d; } item_t;
    item_t      q[$];
    int         checks = 0, errors = 0;
    int         m_mode, m_ptr, m_infl, cyc, since_rst;
    logic       m_pin_v, m_err;
    logic [7:0] m_pin_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_ptr = 0; m_infl = 0; since_rst = 0;
        m_pin_v = 0; m_pin_d = 0; m_err = 0;
    endtask

    // Modes: 0 idle, 1 run, 2 drain. Returns are due LAT+1 cycles after their accept.
    task automatic model_check();
        int k;
        bit blank, ret;
        k = -1;
        if (m_mode == 1 && en && m_infl < MAXI)
            for (int j = 0; j < 4; j++)
                if (k < 0 && rv[(m_ptr + j) % 4]) k = (m_ptr + j) % 4;
        blank = since_rst < LAT;
        ret = q.size() > 0 && q[0].due == cyc;
        chk("req_ready", ready1, k < 0 ? 0 : 32'(1 << k));
        chk("rsp_valid", rsp1, ret ? 32'(1 << q[0].k) : 0);
        if (ret) chk("rsp_data", rsp_d1, q[0].d);
        chk("pipe_in_valid", pin_v1, m_pin_v);
        chk("pipe_in_data", pin_d1, m_pin_d);
        chk("idle", idle1, m_mode == 0);
        chk("busy", busy1, m_infl != 0);
        chk("err_orphan", err1, m_err);
        if (k >= 0) begin
            q.push_back('{due: cyc + LAT + 1, k: k, d: rd[k*8 +: 8]});
            m_ptr = (k + 1) % 4;
        end
        if (ret) void'(q.pop_front());
        m_infl += int'(k >= 0) - int'(ret);
        m_err |= inj && !blank && !ret;
        m_pin_v = k >= 0;
        m_pin_d = k >= 0 ? rd[k*8 +: 8] : 8'h00;
        if (m_mode == 0) m_mode = en ? 1 : 0;
        else if (m_mode == 1) m_mode = en ? 1 : 2;
        else m_mode = en ? 1 : (m_infl == 0 ? 0 : 2);
        cyc++;
        since_rst++;
    endtask

    task automatic run_cycle(input logic e, input logic [3:0] v, input logic [31:0] d, input logic j);
        en = e; rv = v; rd = d; inj = j;
        #1;
        model_check();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; en = 0; rv = 0; inj = 0;
        #1;
        chk("rst_pipe_in_valid", pin_v1, 0);
        chk("rst_pipe_in_data", pin_d1, 0);
        chk("rst_req_ready", ready1, 0);
        chk("rst_rsp_valid", rsp1, 0);
        chk("rst_idle", idle1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_err", err1, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        do_reset();
        // Stale output during blanking is ignored; later orphan is flagged.
        for (int c = 0; c < 24; c++) run_cycle(0, 0, 0, c == 3 || c == 20);
        chk("orphan_sticky", err1, 1);
        do_reset();
        // Single request from requester 0.
        run_cycle(1, 0, 0, 0);
        run_cycle(1, 4'b0001, 32'h0000_00A5, 0);
        for (int c = 0; c < 10; c++) run_cycle(1, 0, 0, 0);
        do_reset();
        // All requesters valid: rotation 0,1,2,3 and cap at eight in flight.
        run_cycle(1, 0, 0, 0);
        for (int c = 0; c < 10; c++) run_cycle(1, 4'b1111, $urandom, 0);
        for (int c = 0; c < 14; c++) run_cycle(1, 0, 0, 0);
        // Disable with three items in flight, then drain to idle.
        for (int c = 0; c < 3; c++) run_cycle(1, 4'b1111, $urandom, 0);
        for (int c = 0; c < 12; c++) run_cycle(0, 4'b1111, $urandom, 0);
        // Random traffic with occasional enable drops.
        for (int c = 0; c < 300; c++) run_cycle($urandom_range(0, 9) != 0, 4'($urandom), $urandom, 0);
        for (int c = 0; c < 20; c++) run_cycle(0, 0, 0, 0);
        // Cap of two: accepts at offsets 0,1 of every 9 cycles, returns 8 later.
        en2 = 1;
        run_cycle(0, 0, 0, 0);
        for (int c = 1; c <= 36; c++) begin
            chk("cap2_ready", ready2, ((c - 1) % 9 < 2) ? 4'b0010 : 4'b0000);
            chk("cap2_rsp", rsp2, (c >= 9 && (c - 9) % 9 < 2) ? 4'b0010 : 4'b0000);
            run_cycle(0, 0, 0, 0);
        end
        en2 = 0;
        do_reset();
        // Reset with five in flight; stale outputs fall inside blanking.
        run_cycle(1, 0, 0, 0);
        for (int c = 0; c < 5; c++) run_cycle(1, 4'b1111, $urandom, 0);
        do_reset();
        for (int c = 0; c < 10; c++) run_cycle(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
